toggle_gen: RTL and testbench

Parametrised NAND-flash strobe generator. After a `start` request it produces `cnt_upto` pulses, each an A phase (`vec_a`, `setup_cyc` clocks) followed by a B phase (`vec_b`, `hold_cyc` clocks). It replaces the fixed 5-bit / fixed-3+2-cycle toggler and adds:
- run-time timing control,
- an idle vector,
- abort,
- pulse-count visibility,
- a one-cycle completion strobe.

It sits between the command sequencer and the NAND pad drivers (RE#/WE#/DQS style strobes).

---
 rtl/toggle_gen_pkg.sv | 8 +
 rtl/toggle_gen_if.sv | 29 ++
 rtl/toggle_phase_timer.sv | 24 ++
 rtl/toggle_gen.sv | 147 ++++++++++++++
 tb/tb_toggle_gen.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/toggle_gen_pkg.sv
// Shared types and default widths for the NAND strobe generator.
package toggle_gen_pkg;
  localparam int VEC_W = 5;
  localparam int CNT_W = 12;
  localparam int DLY_W = 4;

  typedef enum logic [1:0] {IDLE, PH_A, PH_B} state_t;
endpackage

// File: rtl/toggle_gen_if.sv
// Control/strobe bundle between the command sequencer (master) and toggle_gen (slave).
interface toggle_gen_if #(
  parameter int VEC_W = toggle_gen_pkg::VEC_W,
  parameter int CNT_W = toggle_gen_pkg::CNT_W,
  parameter int DLY_W = toggle_gen_pkg::DLY_W
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cnt_upto;
  logic [DLY_W-1:0] setup_cyc;
  logic [DLY_W-1:0] hold_cyc;
  logic [VEC_W-1:0] vec_a;
  logic [VEC_W-1:0] vec_b;
  logic [VEC_W-1:0] vec_idle;
  logic [VEC_W-1:0] out_vec;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    output start, abort, cnt_upto, setup_cyc, hold_cyc, vec_a, vec_b, vec_idle,
    input  out_vec, busy, done, aborted, pulse_cnt
  );
  modport slave (
    input  start, abort, cnt_upto, setup_cyc, hold_cyc, vec_a, vec_b, vec_idle,
    output out_vec, busy, done, aborted, pulse_cnt
  );
endinterface

// File: rtl/toggle_phase_timer.sv
// Phase down-counter: load takes effect next clock (0 clamped to 1); expire marks the last cycle.
module toggle_phase_timer #(
  parameter int DLY_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  output logic             expire
);
  logic [DLY_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? DLY_W'(1) : load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - DLY_W'(1);
    end
  end

  assign expire = (cnt == DLY_W'(1));
endmodule

// File: rtl/toggle_gen.sv
// Burst strobe generator: cnt_upto pulses of vec_a (setup) then vec_b (hold), all outputs registered.
// Outputs follow the sampling edge by one clock; start is ignored while busy, abort only while busy.
module toggle_gen #(
  parameter int VEC_W = toggle_gen_pkg::VEC_W,
  parameter int CNT_W = toggle_gen_pkg::CNT_W,
  parameter int DLY_W = toggle_gen_pkg::DLY_W
) (
  input  logic         clk,
  input  logic         reset,
  toggle_gen_if.slave  bus
);
  import toggle_gen_pkg::*;

  state_t           state, nxt_state;
  logic [VEC_W-1:0] out_vec, nxt_out;
  logic             busy, nxt_busy;
  logic             done, nxt_done;
  logic             aborted, nxt_aborted;
  logic [CNT_W-1:0] pulse_cnt, nxt_pulse_cnt;

  logic [CNT_W-1:0] sh_cnt;
  logic [DLY_W-1:0] sh_setup, sh_hold;
  logic [VEC_W-1:0] sh_a, sh_b;
  logic             shadow_load;

  logic             tmr_load;
  logic [DLY_W-1:0] tmr_val;
  logic             expire;

  toggle_phase_timer #(.DLY_W(DLY_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt_state;
  end

  always_comb begin
    nxt_state     = state;
    nxt_out       = out_vec;
    nxt_busy      = busy;
    nxt_done      = 1'b0;
    nxt_aborted   = 1'b0;
    nxt_pulse_cnt = pulse_cnt;
    tmr_load      = 1'b0;
    tmr_val       = sh_setup;
    shadow_load   = 1'b0;
    case (state)
      IDLE: begin
        nxt_out  = bus.vec_idle;
        nxt_busy = 1'b0;
        if (bus.start) begin
          shadow_load   = 1'b1;
          nxt_pulse_cnt = '0;
          if (bus.cnt_upto == '0) begin
            nxt_done = 1'b1;
          end else begin
            nxt_state = PH_A;
            nxt_out   = bus.vec_a;
            nxt_busy  = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = bus.setup_cyc;
          end
        end
      end
      PH_A: begin
        if (bus.abort) begin
          nxt_state   = IDLE;
          nxt_out     = bus.vec_idle;
          nxt_busy    = 1'b0;
          nxt_aborted = 1'b1;
        end else if (expire) begin
          nxt_state     = PH_B;
          nxt_out       = sh_b;
          tmr_load      = 1'b1;
          tmr_val       = sh_hold;
          nxt_pulse_cnt = pulse_cnt + CNT_W'(1);
        end
      end
      PH_B: begin
        // abort takes priority over completion on the final B cycle
        if (bus.abort) begin
          nxt_state   = IDLE;
          nxt_out     = bus.vec_idle;
          nxt_busy    = 1'b0;
          nxt_aborted = 1'b1;
        end else if (expire) begin
          if (pulse_cnt == sh_cnt) begin
            nxt_state = IDLE;
            nxt_out   = bus.vec_idle;
            nxt_busy  = 1'b0;
            nxt_done  = 1'b1;
          end else begin
            nxt_state = PH_A;
            nxt_out   = sh_a;
            tmr_load  = 1'b1;
            tmr_val   = sh_setup;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vec   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      out_vec   <= nxt_out;
      busy      <= nxt_busy;
      done      <= nxt_done;
      aborted   <= nxt_aborted;
      pulse_cnt <= nxt_pulse_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_cnt   <= '0;
      sh_setup <= '0;
      sh_hold  <= '0;
      sh_a     <= '0;
      sh_b     <= '0;
    end else if (shadow_load) begin
      sh_cnt   <= bus.cnt_upto;
      sh_setup <= bus.setup_cyc;
      sh_hold  <= bus.hold_cyc;
      sh_a     <= bus.vec_a;
      sh_b     <= bus.vec_b;
    end
  end

  assign bus.out_vec   = out_vec;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.aborted   = aborted;
  assign bus.pulse_cnt = pulse_cnt;
endmodule

// File: tb/tb_toggle_gen.sv
// Directed bench for toggle_gen with a schedule-based reference model checked every cycle.
module tb_toggle_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  toggle_gen_if bus ();
  toggle_gen dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  // reference model: burst position derived from cycles elapsed since start
  bit         m_act;
  int         m_c, m_n, m_s, m_h;
  logic [4:0] m_a, m_b;
  logic [4:0] e_out;
  logic       e_busy, e_done, e_ab;
  logic [11:0] e_pc;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void set_phase();
    int p, pos, k;
    p   = m_s + m_h;
    pos = (m_c - 1) % p;
    k   = (m_c - 1) / p + 1;
    e_busy = 1'b1;
    if (pos < m_s) begin
      e_out = m_a;
      e_pc  = 12'(k - 1);
    end else begin
      e_out = m_b;
      e_pc  = 12'(k);
    end
  endfunction

  task automatic model_step();
    e_done = 1'b0;
    e_ab   = 1'b0;
    if (reset) begin
      m_act = 1'b0; e_out = '0; e_busy = 1'b0; e_pc = '0;
    end else if (m_act) begin
      if (bus.abort) begin
        m_act = 1'b0; e_busy = 1'b0; e_ab = 1'b1; e_out = bus.vec_idle;
      end else begin
        m_c++;
        if (m_c == m_n * (m_s + m_h) + 1) begin
          m_act = 1'b0; e_busy = 1'b0; e_done = 1'b1; e_out = bus.vec_idle; e_pc = 12'(m_n);
        end else begin
          set_phase();
        end
      end
    end else begin
      e_out  = bus.vec_idle;
      e_busy = 1'b0;
      if (bus.start) begin
        m_n  = int'(bus.cnt_upto);
        m_s  = (bus.setup_cyc == 0) ? 1 : int'(bus.setup_cyc);
        m_h  = (bus.hold_cyc == 0) ? 1 : int'(bus.hold_cyc);
        m_a  = bus.vec_a;
        m_b  = bus.vec_b;
        e_pc = '0;
        if (m_n == 0) e_done = 1'b1;
        else begin
          m_act = 1'b1; m_c = 1; set_phase();
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("out_vec",   int'(bus.out_vec),   int'(e_out));
    chk("busy",      int'(bus.busy),      int'(e_busy));
    chk("done",      int'(bus.done),      int'(e_done));
    chk("aborted",   int'(bus.aborted),   int'(e_ab));
    chk("pulse_cnt", int'(bus.pulse_cnt), int'(e_pc));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg(input int n, input int s, input int h, input logic [4:0] a, input logic [4:0] b);
    bus.cnt_upto  = 12'(n);
    bus.setup_cyc = 4'(s);
    bus.hold_cyc  = 4'(h);
    bus.vec_a     = a;
    bus.vec_b     = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.vec_idle = 5'h0A;
    cfg(0, 0, 0, 5'h00, 5'h00);
    m_act = 1'b0; m_c = 0; m_n = 0; m_s = 1; m_h = 1; m_a = '0; m_b = '0;

    // reset state, then idle vector one clock after release
    ticks(2);
    chk("rst_out", int'(bus.out_vec), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_pc", int'(bus.pulse_cnt), 0);
    reset = 1'b0;
    tick();
    chk("idle_vec", int'(bus.out_vec), 'h0A);

    // basic burst 4 x (3 + 2)
    cfg(4, 3, 2, 5'h1F, 5'h00);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("basic_c1_out", int'(bus.out_vec), 'h1F);
    chk("basic_c1_busy", int'(bus.busy), 1);
    ticks(3);
    chk("basic_c4_out", int'(bus.out_vec), 'h00);
    chk("basic_c4_pc", int'(bus.pulse_cnt), 1);
    ticks(17);
    chk("basic_c21_done", int'(bus.done), 1);
    chk("basic_c21_pc", int'(bus.pulse_cnt), 4);
    chk("basic_c21_out", int'(bus.out_vec), 'h0A);
    tick();
    chk("basic_c22_done", int'(bus.done), 0);

    // zero clamps
    cfg(3, 0, 0, 5'h1F, 5'h00);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("zero_c1_out", int'(bus.out_vec), 'h1F);
    tick();
    chk("zero_c2_out", int'(bus.out_vec), 'h00);
    chk("zero_c2_pc", int'(bus.pulse_cnt), 1);
    ticks(5);
    chk("zero_c7_done", int'(bus.done), 1);
    chk("zero_c7_pc", int'(bus.pulse_cnt), 3);
    cfg(0, 3, 2, 5'h1F, 5'h00);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("cnt0_done", int'(bus.done), 1);
    chk("cnt0_busy", int'(bus.busy), 0);
    tick();
    chk("cnt0_done_off", int'(bus.done), 0);

    // abort in cycle 9, then on the final B cycle
    cfg(4, 3, 2, 5'h1F, 5'h00);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    ticks(8);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("abort_out", int'(bus.out_vec), 'h0A);
    chk("abort_flag", int'(bus.aborted), 1);
    chk("abort_nodone", int'(bus.done), 0);
    chk("abort_pc", int'(bus.pulse_cnt), 2);
    tick();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    ticks(19);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("abort_last_flag", int'(bus.aborted), 1);
    chk("abort_last_nodone", int'(bus.done), 0);
    chk("abort_last_pc", int'(bus.pulse_cnt), 4);
    tick();
    chk("abort_last_off", int'(bus.aborted), 0);

    // start with abort in idle: start wins
    cfg(1, 1, 1, 5'h1F, 5'h00);
    bus.start = 1'b1; bus.abort = 1'b1; tick(); bus.start = 1'b0; bus.abort = 1'b0;
    chk("startabort_busy", int'(bus.busy), 1);
    ticks(2);
    chk("startabort_done", int'(bus.done), 1);

    // back-to-back with start held high and mid-burst input changes
    cfg(4, 3, 2, 5'h1F, 5'h00);
    bus.start = 1'b1; tick();
    ticks(3);
    cfg(2, 1, 2, 5'h03, 5'h00);
    ticks(17);
    chk("b2b_c21_done", int'(bus.done), 1);
    chk("b2b_c21_pc", int'(bus.pulse_cnt), 4);
    tick();
    chk("b2b_c22_busy", int'(bus.busy), 1);
    chk("b2b_c22_out", int'(bus.out_vec), 'h03);
    bus.start = 1'b0;
    tick();
    chk("b2b_c23_out", int'(bus.out_vec), 'h00);
    chk("b2b_c23_pc", int'(bus.pulse_cnt), 1);
    ticks(5);
    chk("b2b_c28_done", int'(bus.done), 1);
    chk("b2b_c28_pc", int'(bus.pulse_cnt), 2);

    // mid-burst asynchronous reset
    cfg(4, 3, 2, 5'h1F, 5'h00);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    ticks(6);
    reset = 1'b1;
    #1;
    chk("arst_out", int'(bus.out_vec), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_pc", int'(bus.pulse_cnt), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("arst_idle_vec", int'(bus.out_vec), 'h0A);
    cfg(2, 2, 1, 5'h15, 5'h04);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("fresh_c1_out", int'(bus.out_vec), 'h15);
    ticks(6);
    chk("fresh_c7_done", int'(bus.done), 1);
    chk("fresh_c7_pc", int'(bus.pulse_cnt), 2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
